// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_sched
// Description : Round-robin scheduler sharing one registered-latency ALU
//               between NREQ valid/ready requesters.
//               Optional macro ALU_SCHED_LOCAL_ZERO_EN: derive the zero flag
//               from alu_out locally instead of using alu_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sched #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_op,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic                    alu_sum,
    output logic                    alu_sub,
    output logic                    alu_fi,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    input  logic [WIDTH-1:0]        alu_out,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             w_found;
    logic [IDXW-1:0]  w_winner;
    logic             w_zero_in;

`ifdef ALU_SCHED_LOCAL_ZERO_EN
    assign w_zero_in = (alu_out == '0);
`else
    assign w_zero_in = alu_zero;
`endif

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin : p_arb
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = IDXW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_idle;
            ptr_q   <= IDXW'(NREQ - 1);
            owner_q <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            c_idle: begin
                if (w_found) begin
                    op_d    = req_op[w_winner];
                    a_d     = req_a[w_winner*WIDTH +: WIDTH];
                    b_d     = req_b[w_winner*WIDTH +: WIDTH];
                    owner_d = w_winner;
                    ptr_d   = w_winner;
                    state_d = c_issue;
                end
            end
            c_issue: begin
                cnt_d   = CW'(ALU_LAT - 1);
                state_d = c_wait;
            end
            c_wait: begin
                if (cnt_q == '0) begin
                    data_d  = alu_out;
                    carry_d = alu_carry;
                    zero_d  = w_zero_in;
                    state_d = c_resp;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            c_resp: begin
                if (rsp_ready[owner_q]) begin
                    state_d = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    // Grant is gated by rst so nothing is offered while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = !rst && (state_q == c_idle) && w_found && (int'(w_winner) == i);
            rsp_valid[i] = (state_q == c_resp) && (int'(owner_q) == i);
        end
        alu_sum   = (state_q == c_issue) && !op_q;
        alu_sub   = (state_q == c_issue) && op_q;
        alu_fi    = (state_q == c_wait);
        alu_a     = a_q;
        alu_b     = b_q;
        rsp_data  = data_q;
        rsp_carry = carry_q;
        rsp_zero  = zero_q;
        busy      = (state_q != c_idle);
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sched
// Description : Bench for alu_sched with a behavioural latency ALU and a
//               round-robin/arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sched;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 2;
    localparam int ALU_LAT = 3;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_carry;
    logic                  rsp_zero;
    logic                  alu_sum;
    logic                  alu_sub;
    logic                  alu_fi;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [WIDTH-1:0]      alu_out;
    logic                  alu_carry;
    logic                  alu_zero;
    logic                  busy;

    int tests;
    int fails;
    int last_grant;

    alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_sum(alu_sum), .alu_sub(alu_sub), .alu_fi(alu_fi),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: result is only correct once fi has been high long
    // enough; before that it presents inverted values.
    logic [WIDTH:0] alu_res;
    int             alu_fcnt;
    logic           alu_ok;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res  <= '0;
            alu_fcnt <= 0;
        end else if (alu_sum || alu_sub) begin
            alu_res  <= alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
            alu_fcnt <= 0;
        end else if (alu_fi) begin
            alu_fcnt <= alu_fcnt + 1;
        end
    end
    assign alu_ok    = alu_fi && (alu_fcnt >= ALU_LAT - 1);
    assign alu_out   = alu_ok ? alu_res[WIDTH-1:0] : ~alu_res[WIDTH-1:0];
    assign alu_carry = alu_ok ? alu_res[WIDTH] : ~alu_res[WIDTH];
    assign alu_zero  = alu_ok ? (alu_res[WIDTH-1:0] == '0) : (alu_res[WIDTH-1:0] != '0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_op[i]            = op;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // One full transaction from a settled IDLE grant to the return to IDLE.
    task automatic do_op(input int bp);
        int              w;
        logic [NREQ-1:0] oh;
        logic [WIDTH:0]  r;
        logic [WIDTH-1:0] a, b;
        logic            op;
        #1;
        w  = rr_pick(req_valid, last_grant);
        oh = '0;
        if (w >= 0) oh[w] = 1'b1;
        chk("grant", req_ready, oh);
        if (w < 0) return;
        a  = req_a[w*WIDTH +: WIDTH];
        b  = req_b[w*WIDTH +: WIDTH];
        op = req_op[w];
        r  = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        rsp_ready = (bp > 0) ? ~oh : '1;
        @(posedge clk);
        last_grant = w;
        @(negedge clk);
        chk("issue_ctl", {alu_sum, alu_sub, alu_fi, busy, req_ready}, {!op, op, 1'b0, 1'b1, 2'b00});
        chk("issue_opnd", {alu_a, alu_b}, {a, b});
        set_req(w, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        for (int c = 0; c < ALU_LAT; c++) begin
            @(negedge clk);
            chk("wait_ctl", {alu_sum, alu_sub, alu_fi, rsp_valid, req_ready, alu_a, alu_b},
                {1'b0, 1'b0, 1'b1, 2'b00, 2'b00, a, b});
        end
        @(negedge clk);
        chk("rsp", {rsp_valid, rsp_data, rsp_carry, rsp_zero, alu_fi, busy},
            {oh, r[WIDTH-1:0], r[WIDTH], (r[WIDTH-1:0] == '0), 1'b0, 1'b1});
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_data, rsp_carry, req_ready}, {oh, r[WIDTH-1:0], r[WIDTH], 2'b00});
        end
        rsp_ready = '1;
        @(negedge clk);
        chk("back_idle", {busy, rsp_valid}, {1'b0, 2'b00});
    endtask

    initial begin
        logic [NREQ-1:0] e;
        tests = 0; fails = 0; last_grant = NREQ - 1;
        rst = 1'b1; req_valid = '1; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", {req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero,
                               alu_sum, alu_sub, alu_fi, alu_a, alu_b, busy}, 64'd0);
        end

        // Add with carry from requester 0, first grant after reset.
        set_req(0, 1'b0, 8'hF0, 8'h20);
        req_valid = 2'b01;
        rst = 1'b0;
        do_op(0);

        // Abort in the middle of WAIT.
        req_valid = 2'b10;
        set_req(1, 1'b0, 8'h33, 8'h44);
        #1;
        chk("abort_grant", req_ready, 2'b10);
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_async", {busy, alu_fi, rsp_valid, req_ready}, {1'b0, 1'b0, 2'b00, 2'b00});
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_grant = NREQ - 1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_rsp", {busy, rsp_valid}, {1'b0, 2'b00});
        end

        // Fairness with both requesters continuously valid.
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            #1;
            e = '0;
            e[i % NREQ] = 1'b1;
            chk("rr_order", req_ready, e);
            do_op(0);
        end

        // Backpressure while in RESP.
        req_valid = 2'b01;
        do_op(5);

        // Subtract to zero from requester 1.
        req_valid = 2'b10;
        set_req(1, 1'b1, 8'h05, 8'h05);
        do_op(0);

        // Random traffic.
        for (int n = 0; n < 12; n++) begin
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            do_op(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
